link_fifo: RTL
==============

// Module: link_fifo
// PURPOSE
//   Synchronous FIFO on the one-way token link. Sits directly downstream of the
//   N:1 interconnect: absorbs SEND_VALID/SEND_DATA and re-issues them to the
//   consuming stage. Decouples arbitration from consumer stalls.
//   First-word-fall-through: the head entry is always presented on SEND_DATA.
// PARAMETERS
//   DATA_WIDTH  32  width of one token
//   DEPTH       4   number of entries; legal range >= 2, need not be a power of 2
//   CNT_WIDTH   3   width of COUNT; must satisfy 2**CNT_WIDTH > DEPTH
// PORTS
//   CLK            in   1           clock; all state updates on the rising edge
//   RST            in   1           synchronous reset, active-high
//   RECEIVE_VALID  in   1           upstream token valid (from interconnect SEND_VALID)
//   RECEIVE_DATA   in   DATA_WIDTH  upstream token
//   RECEIVE_READY  out  1           FIFO can accept a token this cycle
//   SEND_VALID     out  1           head entry valid
//   SEND_DATA      out  DATA_WIDTH  head entry
//   SEND_READY     in   1           downstream accepts the head this cycle
//   COUNT          out  CNT_WIDTH   current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Storage: DEPTH x DATA_WIDTH register array; rd_ptr and wr_ptr in 0..DEPTH-1; count register.
//   - push = RECEIVE_VALID && RECEIVE_READY; pop = SEND_VALID && SEND_READY.
//   - RECEIVE_READY = (count != DEPTH). Combinational from count only; never
//     depends on RECEIVE_VALID or SEND_READY (no comb. path through the block).
//   - SEND_VALID = (count != 0); SEND_DATA = mem[rd_ptr]; COUNT = count.
//   - push: mem[wr_ptr] <= RECEIVE_DATA; wr_ptr advances.
//   - pop: rd_ptr advances.
//   - Pointer wrap: a pointer equal to DEPTH-1 advances to 0 (explicit compare, not
//     modulo-2**n).
//   - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Latency: a token pushed at edge k is visible on SEND_VALID/SEND_DATA after
//     edge k (1 cycle). Pop frees space visible on RECEIVE_READY after that edge.
//   - Full (count == DEPTH): RECEIVE_READY=0, so no push even if SEND_READY=1 the
//     same cycle. A simultaneous pop still occurs; ready rises next cycle.
//   - Empty (count == 0): SEND_VALID=0, so SEND_READY is ignored. A push in the same
//     cycle is not bypassed to the output.
//   - Simultaneous push and pop with 0 < count < DEPTH: both occur; count unchanged.
//   - Data ordering is strict FIFO; no token is dropped or duplicated.
//   - Reset (RST=1 at an edge, any occupancy): rd_ptr=wr_ptr=count=0 and all mem
//     entries cleared to 0. Push and pop are suppressed that cycle.
//     After reset: SEND_VALID=0, SEND_DATA=0, COUNT=0, RECEIVE_READY=1.
//     Tokens in flight before reset are discarded.
//   - No FSM beyond occupancy; states are EMPTY / PARTIAL / FULL, decoded from count.
// STRUCTURE
//   - Shared package/header: link token width default (32) and the valid/ready
//     handshake-role localparams also used by interconnect-side blocks.
//   - One natural sub-module: link_fifo_ptr (wrapping pointer register with
//     advance enable and synchronous clear), instantiated twice (rd, wr).
//   - Everything else is inline: storage array, count register, and the
//     ready/valid decode.
// TESTING
//   1. Reset then idle: after RST for 2 cycles -> SEND_VALID=0, COUNT=0,
//      RECEIVE_READY=1, SEND_DATA=0.
//   2. Fill, SEND_READY=0: push 0xA0..0xA3 on 4 consecutive cycles -> COUNT=4,
//      RECEIVE_READY=0. A 5th token 0xA4 held valid is not accepted.
//   3. Drain: SEND_READY=1 -> SEND_DATA reads 0xA0,0xA1,0xA2,0xA3 on successive
//      cycles, then SEND_VALID=0, COUNT=0.
//   4. Full plus pop: at COUNT=4, assert RECEIVE_VALID and SEND_READY together ->
//      pop only, COUNT=3. Next cycle RECEIVE_READY=1 and the held token is pushed.
//   5. Streaming wrap: continuous push and pop for 10 tokens (0x10..0x19) starting
//      with COUNT=1 -> COUNT stays 1, output order exact, pointers wrap twice.
//   6. Reset mid-operation: at COUNT=3, assert RST one cycle with RECEIVE_VALID=1 ->
//      COUNT=0, SEND_VALID=0 next cycle, and no stale token emerges afterward.

Source files
------------

// File: rtl/link_fifo_pkg.sv
// Shared link definitions: token width, handshake roles, and FIFO occupancy decode.
package link_fifo_pkg;

    localparam int unsigned LINK_TOKEN_WIDTH = 32;

    // Which side of a valid/ready pair a port plays; shared with interconnect blocks.
    localparam logic HS_ROLE_SOURCE = 1'b0;
    localparam logic HS_ROLE_SINK   = 1'b1;
    localparam logic LINK_FIFO_RECEIVE_ROLE = HS_ROLE_SINK;
    localparam logic LINK_FIFO_SEND_ROLE    = HS_ROLE_SOURCE;

    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    function automatic logic [1:0] occ_decode(input int unsigned count, input int unsigned depth);
        if (count == 0)
            return OCC_EMPTY;
        else if (count >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/link_fifo_ptr.sv
// Wrapping FIFO pointer, 0..DEPTH-1, with advance enable and synchronous clear.
module link_fifo_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance) begin
            // Explicit wrap so non-power-of-2 depths never reach an unused slot.
            if (ptr == PTR_W'(DEPTH - 1))
                ptr <= '0;
            else
                ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/link_fifo.sv
// First-word-fall-through FIFO on the one-way token link, between interconnect and consumer.
module link_fifo
    import link_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LINK_TOKEN_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RECEIVE_VALID,
    input  logic [DATA_WIDTH-1:0] RECEIVE_DATA,
    output logic                  RECEIVE_READY,
    output logic                  SEND_VALID,
    output logic [DATA_WIDTH-1:0] SEND_DATA,
    input  logic                  SEND_READY,
    output logic [CNT_WIDTH-1:0]  COUNT
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [1:0]            occ;
    logic                  push;
    logic                  pop;

    // Ready/valid depend on count alone, so there is no combinational path through the block.
    always_comb begin
        occ           = occ_decode(32'(count), DEPTH);
        RECEIVE_READY = (occ != OCC_FULL);
        SEND_VALID    = (occ != OCC_EMPTY);
        push          = RECEIVE_VALID && RECEIVE_READY;
        pop           = SEND_VALID && SEND_READY;
        SEND_DATA     = mem[rd_ptr];
        COUNT         = count;
    end

    link_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk     (CLK),
        .rst     (RST),
        .advance (push),
        .ptr     (wr_ptr)
    );

    link_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk     (CLK),
        .rst     (RST),
        .advance (pop),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= RECEIVE_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            count <= '0;
        else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
